clk_rst_seq: RTL and testbench

Lock-qualified reset sequencer that sits directly downstream of the board clock generator. It consumes the asynchronous DCM `LOCKED` indication and produces the design-wide synchronous `BUS_RST` in the `BUS_CLK` domain. `BUS_RST` is released only after lock has been continuously stable for a programmable time, followed by a reset hold period. The block also keeps sticky lock-loss status for firmware.

---
 rtl/clk_rst_seq.sv | 135 +++++++++++++
 tb/tb_clk_rst_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// Lock-qualified reset sequencer: synchronizes the DCM LOCKED indication and
// releases BUS_RST only after lock has been stable and a hold period has elapsed.
module clk_rst_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 RST_N,
  input  logic                 LOCKED,
  input  logic                 SOFT_RST,
  input  logic                 CLR_STATUS,
  output logic                 BUS_RST,
  output logic                 READY,
  output logic                 LOCK_LOST,
  output logic [CNT_WIDTH-1:0] LOSS_CNT,
  output logic [1:0]           STATE
);

  localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   bus_rst_q, bus_rst_d;
  logic                   ready_q, ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [CNT_WIDTH-1:0]   loss_cnt_q, loss_cnt_d;
  logic                   locked_s;
  logic                   loss;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], LOCKED};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sync_q      <= '0;
      bus_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      bus_rst_q   <= bus_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  // Loss of synchronized lock wins over every other transition, including SOFT_RST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          loss    = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          loss    = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          loss    = 1'b1;
        end else if (SOFT_RST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    bus_rst_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
    lock_lost_d = CLR_STATUS ? 1'b0 : lock_lost_q;
    loss_cnt_d  = CLR_STATUS ? '0 : loss_cnt_q;
    if (loss) begin
      lock_lost_d = 1'b1;
      if (loss_cnt_d != {CNT_WIDTH{1'b1}}) loss_cnt_d = loss_cnt_d + CNT_WIDTH'(1);
    end
  end

  assign BUS_RST   = bus_rst_q;
  assign READY     = ready_q;
  assign LOCK_LOST = lock_lost_q;
  assign LOSS_CNT  = loss_cnt_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with SYNC_STAGES=2, STABLE_CYCLES=8,
// HOLD_CYCLES=4, CNT_WIDTH=2; edge k is the k-th posedge after a stimulus change.
module tb_clk_rst_seq;

  logic       bus_clk;
  logic       rst_n;
  logic       locked;
  logic       soft_rst;
  logic       clr_status;
  logic       bus_rst;
  logic       ready;
  logic       lock_lost;
  logic [1:0] loss_cnt;
  logic [1:0] state;

  int compared   = 0;
  int mismatched = 0;

  clk_rst_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .CNT_WIDTH    (2)
  ) dut (
    .BUS_CLK   (bus_clk),
    .RST_N     (rst_n),
    .LOCKED    (locked),
    .SOFT_RST  (soft_rst),
    .CLR_STATUS(clr_status),
    .BUS_RST   (bus_rst),
    .READY     (ready),
    .LOCK_LOST (lock_lost),
    .LOSS_CNT  (loss_cnt),
    .STATE     (state)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    locked     = 1'b1;
    soft_rst   = 1'b0;
    clr_status = 1'b0;

    // Reset held with LOCKED high: nothing may move
    for (int i = 0; i < 4; i++) begin
      wait_edges(1);
      check_output("rst_bus_rst", bus_rst, 1);
      check_output("rst_ready", ready, 0);
      check_output("rst_state", state, 0);
      check_output("rst_loss_cnt", loss_cnt, 0);
      check_output("rst_lock_lost", lock_lost, 0);
    end

    // Nominal release
    rst_n = 1'b1;
    wait_edges(2);
    check_output("nom_state_e2", state, 0);
    wait_edges(1);
    check_output("nom_state_e3", state, 1);
    wait_edges(7);
    check_output("nom_state_e10", state, 1);
    wait_edges(1);
    check_output("nom_state_e11", state, 2);
    check_output("nom_bus_rst_e11", bus_rst, 1);
    wait_edges(3);
    check_output("nom_state_e14", state, 2);
    check_output("nom_bus_rst_e14", bus_rst, 1);
    check_output("nom_ready_e14", ready, 0);
    wait_edges(1);
    check_output("nom_state_e15", state, 3);
    check_output("nom_bus_rst_e15", bus_rst, 0);
    check_output("nom_ready_e15", ready, 1);

    // Soft reset in RUN: BUS_RST high for exactly 4 edges
    soft_rst = 1'b1;
    wait_edges(1);
    soft_rst = 1'b0;
    check_output("soft_state_n", state, 2);
    check_output("soft_bus_rst_n", bus_rst, 1);
    for (int i = 1; i < 4; i++) begin
      wait_edges(1);
      check_output("soft_bus_rst_hold", bus_rst, 1);
    end
    wait_edges(1);
    check_output("soft_bus_rst_n4", bus_rst, 0);
    check_output("soft_state_n4", state, 3);

    // Loss in RUN, then clear status
    locked = 1'b0;
    wait_edges(2);
    check_output("runloss_ready_m1", ready, 1);
    check_output("runloss_bus_rst_m1", bus_rst, 0);
    wait_edges(2);
    check_output("runloss_bus_rst_m3", bus_rst, 1);
    check_output("runloss_ready_m3", ready, 0);
    check_output("runloss_state_m3", state, 0);
    check_output("runloss_loss_cnt", loss_cnt, 1);
    check_output("runloss_lock_lost", lock_lost, 1);
    clr_status = 1'b1;
    wait_edges(1);
    clr_status = 1'b0;
    check_output("clr_lock_lost", lock_lost, 0);
    check_output("clr_loss_cnt", loss_cnt, 0);

    // Loss 5 cycles into STABLE
    locked = 1'b1;
    wait_edges(3);
    check_output("stloss_state_e3", state, 1);
    wait_edges(2);
    locked = 1'b0;
    wait_edges(2);
    check_output("stloss_state_m1", state, 1);
    wait_edges(2);
    check_output("stloss_state_m3", state, 0);
    check_output("stloss_loss_cnt", loss_cnt, 1);
    check_output("stloss_lock_lost", lock_lost, 1);

    // Relock: full sequence from cnt=0, with SOFT_RST in STABLE ignored
    locked = 1'b1;
    wait_edges(3);
    check_output("relock_state_e3", state, 1);
    soft_rst = 1'b1;
    wait_edges(1);
    soft_rst = 1'b0;
    check_output("softstable_state_e4", state, 1);
    wait_edges(6);
    check_output("relock_state_e10", state, 1);
    wait_edges(1);
    check_output("relock_state_e11", state, 2);
    wait_edges(3);
    check_output("relock_state_e14", state, 2);
    wait_edges(1);
    check_output("relock_state_e15", state, 3);
    check_output("relock_bus_rst_e15", bus_rst, 0);

    // SOFT_RST coincident with loss: loss wins
    locked = 1'b0;
    wait_edges(2);
    check_output("coinc_state_pre", state, 3);
    soft_rst = 1'b1;
    wait_edges(1);
    soft_rst = 1'b0;
    check_output("coinc_state", state, 0);
    check_output("coinc_bus_rst", bus_rst, 1);
    check_output("coinc_loss_cnt", loss_cnt, 2);

    // Three further loss events: the counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      locked = 1'b1;
      wait_edges(3);
      check_output("sat_state_stable", state, 1);
      locked = 1'b0;
      wait_edges(3);
      check_output("sat_state_wait", state, 0);
      check_output("sat_loss_cnt", loss_cnt, 3);
    end
    check_output("sat_lock_lost", lock_lost, 1);

    // CLR_STATUS on the same edge as a loss
    locked = 1'b1;
    wait_edges(3);
    check_output("clrloss_state_stable", state, 1);
    locked = 1'b0;
    wait_edges(2);
    clr_status = 1'b1;
    wait_edges(1);
    clr_status = 1'b0;
    check_output("clrloss_state", state, 0);
    check_output("clrloss_loss_cnt", loss_cnt, 1);
    check_output("clrloss_lock_lost", lock_lost, 1);

    // RST_N pulse in RUN asserts BUS_RST without a clock edge
    locked = 1'b1;
    wait_edges(15);
    check_output("arst_pre_state", state, 3);
    check_output("arst_pre_bus_rst", bus_rst, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_bus_rst", bus_rst, 1);
    check_output("arst_ready", ready, 0);
    check_output("arst_state", state, 0);
    check_output("arst_loss_cnt", loss_cnt, 0);
    rst_n = 1'b1;
    wait_edges(2);
    check_output("arst_restart_e2", state, 0);
    wait_edges(1);
    check_output("arst_restart_e3", state, 1);
    wait_edges(12);
    check_output("arst_restart_e15", state, 3);
    check_output("arst_restart_bus_rst", bus_rst, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
